// File: rtl/audio_pkg.sv
// audio_pkg: shared audio sample type, I2S receiver states and synchronizer depth
package audio_pkg;
  typedef logic signed [31:0] sample_t;
  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} i2s_state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer (d -> lvl) with registered rise/fall pulses aligned to lvl
module sync_edge
  import audio_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s <= {s[SYNC_STAGES-1:0], d};
      rise <= s[SYNC_STAGES-1] & ~s[SYNC_STAGES];
      fall <= ~s[SYNC_STAGES-1] & s[SYNC_STAGES];
    end
  assign lvl = s[SYNC_STAGES];
endmodule

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: I2S ADC deserializer (CLOCK_50/reset_n, AUD_BCLK/AUD_ADCLRCK/AUD_ADCDAT in; sign-extended out_L/out_R, sample_valid and frame_err pulses out)
module i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_BITS = 24,
  parameter int OUT_BITS  = 32
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       AUD_BCLK,
  input  logic                       AUD_ADCLRCK,
  input  logic                       AUD_ADCDAT,
  output logic signed [OUT_BITS-1:0] out_L,
  output logic signed [OUT_BITS-1:0] out_R,
  output logic                       sample_valid,
  output logic                       frame_err
);
  localparam int CW = $clog2(DATA_BITS + 1);
  i2s_state_t state, state_n;
  logic bclk_rise, bclk_fall, bclk_lvl, lr_rise, lr_fall, lr_lvl, lr_edge;
  logic [SYNC_STAGES:0] dat_s;
  logic [CW-1:0] cnt;
  logic [DATA_BITS-1:0] sh, sh_n, hold;
  logic chan, left_ok, done, start, shift_en, commit_l, commit_r, err;
  logic unused_ok;
  sync_edge u_bclk (.clk(CLOCK_50), .rst_n(reset_n), .d(AUD_BCLK), .lvl(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall));
  sync_edge u_lrck (.clk(CLOCK_50), .rst_n(reset_n), .d(AUD_ADCLRCK), .lvl(lr_lvl), .rise(lr_rise), .fall(lr_fall));
  assign unused_ok = &{1'b0, bclk_fall, bclk_lvl};
  assign lr_edge = lr_rise | lr_fall;
  assign sh_n = {sh[DATA_BITS-2:0], dat_s[SYNC_STAGES]};
  assign done = cnt == CW'(DATA_BITS - 1);
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    start = 1'b0;
    shift_en = 1'b0;
    commit_l = 1'b0;
    commit_r = 1'b0;
    err = 1'b0;
    case (state)
      IDLE: state_n = lr_edge ? SKIP : IDLE;
      SKIP: if (!lr_edge && bclk_rise) begin
        start = 1'b1;
        state_n = SHIFT;
      end
      SHIFT: if (lr_edge) begin
        err = 1'b1;
        state_n = SKIP;
      end else if (bclk_rise) begin
        shift_en = 1'b1;
        commit_l = done & ~chan;
        commit_r = done & chan;
        state_n = done ? WAIT : SHIFT;
      end
      WAIT: state_n = lr_edge ? SKIP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      dat_s <= '0;
      cnt <= '0;
      sh <= '0;
      hold <= '0;
      chan <= 1'b0;
      left_ok <= 1'b0;
      out_L <= '0;
      out_R <= '0;
      sample_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dat_s <= {dat_s[SYNC_STAGES-1:0], AUD_ADCDAT};
      sample_valid <= commit_r & left_ok;
      frame_err <= err;
      if (start) begin
        cnt <= '0;
        chan <= lr_lvl;
      end
      if (shift_en) begin
        sh <= sh_n;
        cnt <= cnt + 1'b1;
      end
      if (commit_l) begin
        hold <= sh_n;
        left_ok <= 1'b1;
      end
      if (commit_r || (err && chan)) left_ok <= 1'b0;
      if (commit_r && left_ok) begin
        out_L <= OUT_BITS'(signed'(hold));
        out_R <= OUT_BITS'(signed'(sh_n));
      end
    end
endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: randomized I2S stream checked every cycle against a frame-level model for DATA_BITS 24 and 16
module tb_i2s_adc_rx;
  import audio_pkg::*;
  typedef struct {int k; int c; bit err; sample_t l; sample_t r;} ev_t;
  logic clk = 0, rst_n = 1, bclk = 0, lrck = 0, dat = 0;
  sample_t l24, r24, l16, r16;
  logic sv24, fe24, sv16, fe16;
  int cyc = 0, checks = 0, errors = 0, pulses = 0, errs = 0;
  int db [2] = '{24, 16};
  bit synced [2], ch [2], lv [2];
  int rises [2];
  longint sh [2], hold [2];
  sample_t el [2], er [2];
  ev_t q [$];
  i2s_adc_rx #(.DATA_BITS(24), .OUT_BITS(32)) u_d24 (
    .CLOCK_50(clk), .reset_n(rst_n), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
    .out_L(l24), .out_R(r24), .sample_valid(sv24), .frame_err(fe24));
  i2s_adc_rx #(.DATA_BITS(16), .OUT_BITS(32)) u_d16 (
    .CLOCK_50(clk), .reset_n(rst_n), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck), .AUD_ADCDAT(dat),
    .out_L(l16), .out_R(r16), .sample_valid(sv16), .frame_err(fe16));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
    end
  endfunction
  function automatic longint sext(longint v, int n);
    return v >= (longint'(1) << (n - 1)) ? v - (longint'(1) << n) : v;
  endfunction
  function automatic void push(int k, int c, bit e, sample_t l, sample_t r);
    ev_t x;
    x.k = k; x.c = c; x.err = e; x.l = l; x.r = r;
    q.push_back(x);
  endfunction
  // a word-select change ends the current slot; short only if the data phase had started
  function automatic void m_lr(bit nl);
    for (int k = 0; k < 2; k++) begin
      if (synced[k] && rises[k] >= 1 && rises[k] - 1 < db[k]) begin
        push(k, cyc + 4, 1'b1, 0, 0);
        if (ch[k]) lv[k] = 0;
      end
      synced[k] = 1; rises[k] = 0; sh[k] = 0; ch[k] = nl;
    end
  endfunction
  function automatic void m_rise(bit d);
    for (int k = 0; k < 2; k++) if (synced[k]) begin
      rises[k]++;
      if (rises[k] >= 2 && rises[k] - 1 <= db[k]) sh[k] = sh[k] * 2 + longint'(d);
      if (rises[k] - 1 == db[k]) begin
        if (!ch[k]) begin
          hold[k] = sext(sh[k], db[k]);
          lv[k] = 1;
        end else if (lv[k]) begin
          push(k, cyc + 4, 1'b0, sample_t'(hold[k]), sample_t'(sext(sh[k], db[k])));
          lv[k] = 0;
        end
      end
    end
  endfunction
  function automatic void m_reset();
    q.delete();
    for (int k = 0; k < 2; k++) begin
      synced[k] = 0; lv[k] = 0; rises[k] = 0; el[k] = 0; er[k] = 0;
    end
  endfunction
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit ev, ee;
      ev = 0;
      ee = 0;
      foreach (q[i]) if (q[i].k == k && q[i].c == cyc) begin
        if (q[i].err) ee = 1;
        else begin
          ev = 1; el[k] = q[i].l; er[k] = q[i].r;
        end
      end
      chk($sformatf("valid%0d", db[k]), k ? sv16 : sv24, ev);
      chk($sformatf("frame_err%0d", db[k]), k ? fe16 : fe24, ee);
      chk($sformatf("out_L%0d", db[k]), k ? l16 : l24, el[k]);
      chk($sformatf("out_R%0d", db[k]), k ? r16 : r24, er[k]);
    end
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].c <= cyc) q.delete(i);
    if (sv24) pulses++;
    if (fe24) errs++;
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    m_reset();
    #1;
    chk("rst_out_L", l24, 0);
    chk("rst_out_R", r24, 0);
    chk("rst_valid", sv24, 0);
    tick(3);
    rst_n = 1;
    tick(2);
  endtask
  task automatic period(bit lr_v, bit d_v);
    bclk = 0;
    dat = d_v;
    if (lr_v != lrck) begin
      lrck = lr_v;
      m_lr(lr_v);
    end
    tick(5);
    bclk = 1;
    m_rise(d_v);
    tick(5);
  endtask
  task automatic slot(bit c, logic [31:0] w, int n, bit trail, int rst_at);
    for (int j = 0; j < n; j++) begin
      period(c, (j >= 1 && j <= 32) ? w[32-j] : trail);
      if (j == rst_at) do_reset();
    end
  endtask
  task automatic frame(logic [31:0] wl, logic [31:0] wr);
    slot(0, wl, 32, 0, -1);
    slot(1, wr, 32, 0, -1);
  endtask
  initial begin
    int pc, ec, n;
    #1 rst_n = 0;
    m_reset();
    tick(4);
    chk("por_out_L", l24, 0);
    chk("por_out_R", r24, 0);
    chk("por_err", fe24, 0);
    rst_n = 1;
    tick(3);
    pc = pulses;
    frame(32'h7FFFFF00, 32'h80000000);
    frame(32'h7FFFFF00, 32'h80000000);
    chk("s1_out_L", l24, 32'h007FFFFF);
    chk("s1_out_R", r24, 32'hFF800000);
    chk("s1_pulses", pulses - pc, 1);
    pc = pulses;
    slot(0, 32'h55555555, 32, 0, 5);
    slot(1, 32'h33333300, 32, 0, -1);
    frame(32'h00000100, 32'hFFFFFF00);
    chk("s2_out_L", l24, 32'h00000001);
    chk("s2_out_R", r24, 32'hFFFFFFFF);
    chk("s2_pulses", pulses - pc, 1);
    slot(0, 32'h123456FF, 32, 1, -1);
    slot(1, 32'h0F0F0FFF, 32, 1, -1);
    chk("s3_out_L", l24, 32'h00123456);
    chk("s3_out_L16", l16, 32'h00001234);
    pc = pulses;
    ec = errs;
    slot(0, 32'h11111100, 32, 0, -1);
    slot(1, 32'h22222200, 11, 0, -1);
    slot(0, 32'hA5A5A500, 32, 0, -1);
    chk("s4_hold_L", l24, 32'h00123456);
    chk("s4_errs", errs - ec, 1);
    slot(1, 32'h5A5A5A00, 32, 0, -1);
    chk("s4_out_L", l24, 32'hFFA5A5A5);
    chk("s4_out_R", r24, 32'h005A5A5A);
    chk("s4_pulses", pulses - pc, 1);
    slot(0, 32'h76543200, 32, 0, 10);
    slot(1, 32'h01234500, 32, 0, -1);
    frame(32'h00000100, 32'hFFFFFF00);
    chk("s5_out_L", l24, 32'h00000001);
    chk("s5_out_R", r24, 32'hFFFFFFFF);
    frame(32'h80000000, 32'h7FFF0000);
    chk("s6_out_L16", l16, 32'hFFFF8000);
    chk("s6_out_R16", r16, 32'h00007FFF);
    chk("s6_out_L24", l24, 32'hFF800000);
    for (int i = 0; i < 40; i++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 32;
      slot(i[0], $urandom, n, 1'($urandom_range(0, 1)), (i == 20) ? 3 : -1);
    end
    slot(0, 32'h0, 32, 0, -1);
    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
